// File: rtl/encrypt_sched_if.sv
// Request/response bundle between plaintext requesters, the response consumer
// and the encrypt scheduler. The scheduler takes the slave side.
interface encrypt_sched_if #(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned M_SIZE = 5,
  parameter int unsigned C_W    = 64
);
  localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*M_SIZE-1:0] req_m;
  logic [N_REQ-1:0]        req_ready;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [C_W-1:0]          rsp_c;
  logic [ID_W-1:0]         rsp_id;

  modport master (
    output req_valid, req_m, rsp_ready,
    input  req_ready, rsp_valid, rsp_c, rsp_id
  );

  modport slave (
    input  req_valid, req_m, rsp_ready,
    output req_ready, rsp_valid, rsp_c, rsp_id
  );
endinterface

// File: rtl/encrypt_sched.sv
// Sequencer/arbiter for the single non-pipelined encrypt core: owns the key
// set, seeds the core noise generators after each key load, shares the core
// round-robin between requesters and returns tagged ciphertexts.
module encrypt_sched #(
  parameter int unsigned M_SIZE   = 5,
  parameter int unsigned LAMBDA   = 32,
  parameter int unsigned ETA      = 32,
  parameter int unsigned NU       = 16,
  parameter int unsigned C_W      = (2 * NU > ETA + LAMBDA) ? 2 * NU : ETA + LAMBDA,
  parameter int unsigned N_REQ    = 2,
  parameter int unsigned CORE_LAT = 3,
  parameter int unsigned SEED_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [ETA-1:0]    cfg_q,
  input  logic [LAMBDA-1:0] cfg_p,
  input  logic [NU-1:0]     cfg_kappa,
  output logic              cfg_ready,
  output logic              cfg_err,
  encrypt_sched_if.slave    bus,
  output logic [ETA-1:0]    core_q,
  output logic [LAMBDA-1:0] core_p,
  output logic [NU-1:0]     core_kappa,
  output logic [M_SIZE-1:0] core_m,
  output logic              core_rand_reset,
  input  logic [C_W-1:0]    core_c,
  output logic [15:0]       jobs_done
);

  localparam int unsigned ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned SW      = ID_W + 1;
  localparam int unsigned CNT_MAX = (CORE_LAT > SEED_CYC) ? CORE_LAT : SEED_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {StUnkeyed, StSeed, StIdle, StRun, StResp} state_e;

  state_e            state_q;
  logic [ID_W-1:0]   ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              rsp_valid_q;
  logic [C_W-1:0]    rsp_c_q;
  logic [ID_W-1:0]   rsp_id_q;

  logic              key_ok;
  logic              cfg_take;
  logic              found;
  logic              accept;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   ptr_next;
  logic [M_SIZE-1:0] m_sel;

  assign cfg_ready = (state_q == StUnkeyed) || (state_q == StIdle);
  assign key_ok    = (|cfg_q) && (|cfg_p) && (|cfg_kappa);
  assign cfg_take  = cfg_we && cfg_ready;
  // A key load in the same cycle always wins over a pending request.
  assign accept    = (state_q == StIdle) && !cfg_we && found;

  assign bus.req_ready = accept ? (N_REQ'(1) << grant) : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_c     = rsp_c_q;
  assign bus.rsp_id    = rsp_id_q;

  // Round-robin search from the pointer upward, plus the granted plaintext slice.
  always_comb begin : p_arb
    logic [SW-1:0] idx;
    logic [SW-1:0] nxt;
    found = 1'b0;
    grant = '0;
    idx   = '0;
    m_sel = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = SW'(ptr_q) + SW'(k);
      if (idx >= SW'(N_REQ)) idx = idx - SW'(N_REQ);
      if (!found && bus.req_valid[idx[ID_W-1:0]]) begin
        found = 1'b1;
        grant = idx[ID_W-1:0];
      end
    end
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (ID_W'(j) == grant) m_sel = bus.req_m[j*M_SIZE +: M_SIZE];
    end
    nxt = SW'(grant) + SW'(1);
    if (nxt >= SW'(N_REQ)) nxt = '0;
    ptr_next = nxt[ID_W-1:0];
  end

  // Controller FSM with all core-facing and response outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StUnkeyed;
      ptr_q           <= '0;
      cnt_q           <= '0;
      core_q          <= '0;
      core_p          <= '0;
      core_kappa      <= '0;
      core_m          <= '0;
      core_rand_reset <= 1'b1;
      cfg_err         <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_c_q         <= '0;
      rsp_id_q        <= '0;
      jobs_done       <= '0;
    end else begin
      cfg_err <= 1'b0;
      unique case (state_q)
        StUnkeyed, StIdle: begin
          if (cfg_take) begin
            if (!key_ok) begin
              cfg_err <= 1'b1;
            end else begin
              core_q          <= cfg_q;
              core_p          <= cfg_p;
              core_kappa      <= cfg_kappa;
              core_rand_reset <= 1'b1;
              cnt_q           <= CNT_W'(SEED_CYC);
              state_q         <= StSeed;
            end
          end else if (accept) begin
            core_m   <= m_sel;
            rsp_id_q <= grant;
            ptr_q    <= ptr_next;
            cnt_q    <= CNT_W'(CORE_LAT);
            state_q  <= StRun;
          end
        end
        StSeed: begin
          if (cnt_q == CNT_W'(1)) begin
            core_rand_reset <= 1'b0;
            state_q         <= StIdle;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StRun: begin
          if (cnt_q == CNT_W'(1)) begin
            rsp_c_q     <= core_c;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            jobs_done   <= jobs_done + 16'd1;
            core_m      <= '0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StUnkeyed;
      endcase
    end
  end

endmodule

// File: tb/tb_encrypt_sched.sv
// Bench for encrypt_sched: behavioural core model, table-driven jobs with a
// response scoreboard, plus sequences for seeding, back-pressure and reset.
module tb_encrypt_sched;
  localparam int unsigned M_SIZE = 5;
  localparam int unsigned LAMBDA = 32;
  localparam int unsigned ETA    = 32;
  localparam int unsigned NU     = 16;
  localparam int unsigned C_W    = 64;
  localparam int unsigned N_REQ  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              cfg_we = 1'b0;
  logic [ETA-1:0]    cfg_q = '0;
  logic [LAMBDA-1:0] cfg_p = '0;
  logic [NU-1:0]     cfg_kappa = '0;
  logic              cfg_ready, cfg_err;
  logic [ETA-1:0]    core_q;
  logic [LAMBDA-1:0] core_p;
  logic [NU-1:0]     core_kappa;
  logic [M_SIZE-1:0] core_m;
  logic              core_rand_reset;
  logic [C_W-1:0]    core_c;
  logic [15:0]       jobs_done;

  encrypt_sched_if #(.N_REQ(N_REQ), .M_SIZE(M_SIZE), .C_W(C_W)) bus ();

  encrypt_sched #(
    .M_SIZE(M_SIZE), .LAMBDA(LAMBDA), .ETA(ETA), .NU(NU), .C_W(C_W),
    .N_REQ(N_REQ), .CORE_LAT(3), .SEED_CYC(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_q(cfg_q), .cfg_p(cfg_p), .cfg_kappa(cfg_kappa),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .bus(bus),
    .core_q(core_q), .core_p(core_p), .core_kappa(core_kappa), .core_m(core_m),
    .core_rand_reset(core_rand_reset), .core_c(core_c), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  // Core model: result of a plaintext is valid 3 cycles after core_m settles.
  function automatic logic [63:0] model_c(input logic [4:0] m, input logic [31:0] q,
                                          input logic [15:0] k);
    return 64'(m) + 64'(q) * 64'd13 + 64'(k) * 64'd29;
  endfunction

  logic [4:0] s1 = '0;
  logic [4:0] s2 = '0;
  always @(posedge clk) begin
    s1 <= core_m;
    s2 <= s1;
  end
  assign core_c = model_c(s2, core_q, core_kappa);

  typedef struct {
    logic [0:0]  id;
    logic [63:0] c;
  } exp_t;

  typedef struct {
    logic [1:0] valid;
    logic [4:0] m0;
    logic [4:0] m1;
    int         exp_id;
  } vec_t;

  exp_t sb[$];
  int   acc_cyc[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_jobs = 0;
  logic [31:0] kq = '0;
  logic [15:0] kk = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and accept-time monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      if ((bus.req_valid & bus.req_ready) != 2'b00) acc_cyc.push_back(cyc);
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_rsp: got id %0d c %0h, expected no response",
                   bus.rsp_id, bus.rsp_c);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
          chk("rsp_c", bus.rsp_c, e.c);
        end
      end
    end
  end

  task automatic push_exp(input int id, input logic [4:0] m);
    exp_t e;
    e.id = 1'(id);
    e.c  = model_c(m, kq, kk);
    sb.push_back(e);
    exp_jobs++;
  endtask

  // One complete job: request, latency check, immediate response handshake.
  task automatic run_vec(input vec_t v);
    logic [1:0] oh;
    logic [4:0] ms;
    int lat;
    oh = 2'b01 << v.exp_id;
    ms = (v.exp_id == 1) ? v.m1 : v.m0;
    bus.req_valid = v.valid;
    bus.req_m     = {v.m1, v.m0};
    #1;
    chk("req_ready", 64'(bus.req_ready), 64'(oh));
    push_exp(v.exp_id, ms);
    tick();
    bus.req_valid = 2'b00;
    chk("core_m", 64'(core_m), 64'(ms));
    lat = 0;
    while (!bus.rsp_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk("latency", 64'(lat), 64'd3);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_clr", 64'(bus.rsp_valid), 64'd0);
    chk("jobs_done", 64'(jobs_done), 64'(exp_jobs));
    chk("core_m_idle", 64'(core_m), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int   guard;
    int   lat;
    logic [63:0] hold_c;

    vecs[0] = '{valid: 2'b01, m0: 5'd3,  m1: 5'd0,  exp_id: 0};
    vecs[1] = '{valid: 2'b01, m0: 5'd17, m1: 5'd0,  exp_id: 0};
    vecs[2] = '{valid: 2'b10, m0: 5'd0,  m1: 5'd9,  exp_id: 1};
    vecs[3] = '{valid: 2'b11, m0: 5'd31, m1: 5'd0,  exp_id: 0};
    vecs[4] = '{valid: 2'b11, m0: 5'd1,  m1: 5'd22, exp_id: 1};
    vecs[5] = '{valid: 2'b10, m0: 5'd0,  m1: 5'd31, exp_id: 1};

    bus.req_valid = '0;
    bus.req_m     = '0;
    bus.rsp_ready = 1'b0;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    chk("rst_rand_reset", 64'(core_rand_reset), 64'd1);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_core_q", 64'(core_q), 64'd0);
    chk("rst_jobs", 64'(jobs_done), 64'd0);
    chk("rst_rsp_c", bus.rsp_c, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Unkeyed: requests are never accepted
    bus.req_valid = 2'b11;
    bus.req_m     = {5'd4, 5'd2};
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("unkeyed_req_ready", 64'(bus.req_ready), 64'd0);
      chk("unkeyed_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    end
    bus.req_valid = 2'b00;

    // Rejected key set
    cfg_q = 32'd0; cfg_p = 32'h0000_000B; cfg_kappa = 16'h0005; cfg_we = 1'b1;
    #1;
    chk("bad_cfg_ready", 64'(cfg_ready), 64'd1);
    tick();
    cfg_we = 1'b0;
    chk("cfg_err_pulse", 64'(cfg_err), 64'd1);
    chk("bad_core_q", 64'(core_q), 64'd0);
    tick();
    chk("cfg_err_clear", 64'(cfg_err), 64'd0);
    chk("still_unkeyed", 64'(cfg_ready), 64'd1);

    // Good key set and seeding window
    cfg_q = 32'h0000_0007; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    kq = 32'h0000_0007;
    kk = 16'h0005;
    chk("key_q", 64'(core_q), 64'h7);
    chk("key_p", 64'(core_p), 64'hB);
    chk("key_kappa", 64'(core_kappa), 64'h5);
    for (int i = 0; i < 4; i++) begin
      chk("seed_rand_reset", 64'(core_rand_reset), 64'd1);
      chk("seed_cfg_ready", 64'(cfg_ready), 64'd0);
      tick();
    end
    chk("seed_done_rr", 64'(core_rand_reset), 64'd0);
    chk("seed_done_ready", 64'(cfg_ready), 64'd1);

    // Table-driven jobs
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Both requesters continuously valid: alternating grants, 5-cycle spacing
    acc_cyc.delete();
    bus.req_m     = {5'd12, 5'd6};
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b11;
    push_exp(0, 5'd6);
    push_exp(1, 5'd12);
    push_exp(0, 5'd6);
    push_exp(1, 5'd12);
    guard = 0;
    while (acc_cyc.size() < 4 && guard < 60) begin
      tick();
      guard++;
    end
    bus.req_valid = 2'b00;
    guard = 0;
    while (sb.size() != 0 && guard < 40) begin
      tick();
      guard++;
    end
    bus.rsp_ready = 1'b0;
    tick();
    chk("rr_drain", 64'(sb.size()), 64'd0);
    chk("rr_accepts", 64'(acc_cyc.size()), 64'd4);
    if (acc_cyc.size() >= 4) begin
      for (int i = 1; i < 4; i++) chk("rr_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd5);
    end
    chk("rr_jobs", 64'(jobs_done), 64'(exp_jobs));

    // Back-pressured response while key loads are attempted
    bus.req_valid = 2'b01;
    bus.req_m     = {5'd0, 5'd20};
    push_exp(0, 5'd20);
    hold_c = model_c(5'd20, kq, kk);
    tick();
    bus.req_valid = 2'b00;
    lat = 0;
    while (!bus.rsp_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk("hold_latency", 64'(lat), 64'd3);
    cfg_q = 32'h11; cfg_p = 32'h13; cfg_kappa = 16'h17;
    for (int i = 0; i < 10; i++) begin
      cfg_we = 1'b1;
      #1;
      chk("hold_cfg_ready", 64'(cfg_ready), 64'd0);
      chk("hold_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("hold_rsp_c", bus.rsp_c, hold_c);
      chk("hold_cfg_err", 64'(cfg_err), 64'd0);
      tick();
    end
    cfg_we = 1'b0;
    chk("hold_keys", 64'(core_q), 64'h7);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("hold_jobs", 64'(jobs_done), 64'(exp_jobs));
    chk("hold_no_seed", 64'(core_rand_reset), 64'd0);

    // Reload from IDLE
    cfg_we = 1'b1;
    #1;
    chk("reload_ready", 64'(cfg_ready), 64'd1);
    tick();
    cfg_we = 1'b0;
    kq = 32'h11;
    kk = 16'h17;
    chk("reload_q", 64'(core_q), 64'h11);
    chk("reload_p", 64'(core_p), 64'h13);
    chk("reload_kappa", 64'(core_kappa), 64'h17);
    for (int i = 0; i < 4; i++) begin
      chk("reseed_rand_reset", 64'(core_rand_reset), 64'd1);
      tick();
    end
    chk("reseed_done", 64'(core_rand_reset), 64'd0);
    run_vec('{valid: 2'b01, m0: 5'd9, m1: 5'd0, exp_id: 0});

    // Reset in the middle of a job: job is lost
    bus.req_valid = 2'b10;
    bus.req_m     = {5'd4, 5'd0};
    tick();
    bus.req_valid = 2'b11;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("midrst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("midrst_core_m", 64'(core_m), 64'd0);
    chk("midrst_core_q", 64'(core_q), 64'd0);
    chk("midrst_rand_reset", 64'(core_rand_reset), 64'd1);
    chk("midrst_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("midrst_jobs", 64'(jobs_done), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("postrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("postrst_req_ready", 64'(bus.req_ready), 64'd0);
    end
    chk("postrst_jobs", 64'(jobs_done), 64'd0);
    bus.req_valid = 2'b00;
    tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
